gpu_dispatcher: RTL and testbench

Kernel-level block distributor for the miniGPU. On a kernel launch it divides the total thread count into fixed-size blocks and issues them one at a time to free compute cores. Each issue is a block ID plus a per-block thread count, sent over each core's core_start/core_done handshake to that core's scheduler. It signals kernel completion once every issued block has retired. It sits between the device control register and the NUM_CORES core instances.

---
 rtl/gpu_pkg.sv | 36 +++
 rtl/dispatch_slot.sv | 59 +++++
 rtl/gpu_dispatcher.sv | 151 +++++++++++++++
 tb/tb_gpu_dispatcher.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// ============================================================================
// gpu_pkg: shared state encodings, ID/count width and block-size helper for
// the kernel dispatcher.                                         Rev 1.0
// ============================================================================
`default_nettype none

package gpu_pkg;

   localparam int ID_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } top_state_t;

   typedef enum logic [1:0] {
      FREE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } slot_state_t;

   // Block size is a power of two, so its log2 is the index of its single set bit.
   function automatic int tpb_log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 8; i++) begin
         if ((1 << i) == n) r = i;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_slot.sv
// ============================================================================
// dispatch_slot: per-core issue slot holding the block handed to one core.
//                                                                 Rev 1.0
// ============================================================================
`default_nettype none

module dispatch_slot
   import gpu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            issue,
   input  logic [ID_W-1:0] block_id,
   input  logic [ID_W-1:0] thread_count,
   input  logic            core_done,
   output logic            is_free,
   output logic            retire,
   output logic            core_start,
   output logic [ID_W-1:0] core_block_id,
   output logic [ID_W-1:0] core_thread_count
);

   slot_state_t state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= FREE;
         core_start        <= 1'b0;
         core_block_id     <= '0;
         core_thread_count <= '0;
      end else begin
         core_start <= 1'b0;
         if (clear) begin
            state <= FREE;
         end else begin
            case (state)
               FREE: begin
                  if (issue) begin
                     state             <= START;
                     core_start        <= 1'b1;
                     core_block_id     <= block_id;
                     core_thread_count <= thread_count;
                  end
               end
               START:   state <= BUSY;
               BUSY:    if (core_done) state <= FREE;
               default: state <= FREE;
            endcase
         end
      end
   end

   assign is_free = (state == FREE);
   assign retire  = (state == BUSY) && core_done;

endmodule

`default_nettype wire

// File: rtl/gpu_dispatcher.sv
// ============================================================================
// gpu_dispatcher: splits a kernel into blocks and issues them to free cores.
// Optional launch-to-done cycle counter under DISPATCH_PERF_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module gpu_dispatcher
   import gpu_pkg::*;
#(
   parameter int NUM_CORES         = 2,
   parameter int THREADS_PER_BLOCK = 4
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [7:0]                thread_count,
   input  logic [NUM_CORES-1:0]      core_done,
   output logic [NUM_CORES-1:0]      core_reset,
   output logic [NUM_CORES-1:0]      core_start,
   output logic [NUM_CORES*ID_W-1:0] core_block_id,
   output logic [NUM_CORES*ID_W-1:0] core_thread_count,
   output logic                      done,
   output logic [15:0]               kernel_cycles
);

   localparam int TPB_LOG2 = tpb_log2(THREADS_PER_BLOCK);

   top_state_t           state;
   logic [ID_W-1:0]      total_blocks;
   logic [ID_W-1:0]      blocks_dispatched;
   logic [ID_W-1:0]      blocks_done;
   logic [ID_W-1:0]      tc_latched;
   logic [ID_W-1:0]      retire_cnt;
   logic [ID_W-1:0]      issue_count;
   logic [8:0]           total_calc;
   logic [NUM_CORES-1:0] slot_free;
   logic [NUM_CORES-1:0] slot_retire;
   logic [NUM_CORES-1:0] issue_vec;
   logic                 pick_done;
   logic                 clear_slots;

   assign total_calc  = {1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1);
   assign clear_slots = (state == LAUNCH);

   // Only the final block can be short; its size wraps in 8 bits like the counters.
   assign issue_count = (blocks_dispatched == total_blocks - 8'd1)
                      ? tc_latched - (blocks_dispatched << TPB_LOG2)
                      : ID_W'(THREADS_PER_BLOCK);

   always_comb begin
      issue_vec = '0;
      pick_done = 1'b0;
      if (state == RUN && blocks_dispatched < total_blocks) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (slot_free[i] && !pick_done) begin
               issue_vec[i] = 1'b1;
               pick_done    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      retire_cnt = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         retire_cnt = retire_cnt + ID_W'(slot_retire[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         total_blocks      <= '0;
         blocks_dispatched <= '0;
         blocks_done       <= '0;
         tc_latched        <= '0;
         core_reset        <= '0;
         done              <= 1'b0;
      end else begin
         core_reset <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= LAUNCH;
                  core_reset <= '1;
               end
            end
            LAUNCH: begin
               total_blocks      <= ID_W'(total_calc >> TPB_LOG2);
               tc_latched        <= thread_count;
               blocks_dispatched <= '0;
               blocks_done       <= '0;
               state             <= RUN;
            end
            RUN: begin
               if (|issue_vec) blocks_dispatched <= blocks_dispatched + 8'd1;
               blocks_done <= blocks_done + retire_cnt;
               if (blocks_done == total_blocks) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (!start) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
      dispatch_slot u_slot (
         .clk               (clk),
         .reset             (reset),
         .clear             (clear_slots),
         .issue             (issue_vec[g]),
         .block_id          (blocks_dispatched),
         .thread_count      (issue_count),
         .core_done         (core_done[g]),
         .is_free           (slot_free[g]),
         .retire            (slot_retire[g]),
         .core_start        (core_start[g]),
         .core_block_id     (core_block_id[g*ID_W +: ID_W]),
         .core_thread_count (core_thread_count[g*ID_W +: ID_W])
      );
   end

`ifdef DISPATCH_PERF_EN
   logic [15:0] cycle_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt <= '0;
      end else if (state == LAUNCH) begin
         cycle_cnt <= '0;
      end else if (state == RUN && cycle_cnt != 16'hFFFF) begin
         cycle_cnt <= cycle_cnt + 16'd1;
      end
   end

   assign kernel_cycles = cycle_cnt;
`else
   assign kernel_cycles = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpu_dispatcher.sv
// ============================================================================
// tb_gpu_dispatcher: randomized scoreboard bench for gpu_dispatcher.
//                                                                 Rev 1.0
// ============================================================================
`default_nettype none

module tb_gpu_dispatcher;

   localparam int NC  = 2;
   localparam int TPB = 4;
   localparam int BIG = 1 << 30;

   typedef struct {
      int id;
      int cnt;
   } blk_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic [7:0]      thread_count = 8'd0;
   logic [NC-1:0]   core_done = '0;
   logic [NC-1:0]   core_reset;
   logic [NC-1:0]   core_start;
   logic [NC*8-1:0] core_block_id;
   logic [NC*8-1:0] core_thread_count;
   logic            done;
   logic [15:0]     kernel_cycles;

   gpu_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .thread_count      (thread_count),
      .core_done         (core_done),
      .core_reset        (core_reset),
      .core_start        (core_start),
      .core_block_id     (core_block_id),
      .core_thread_count (core_thread_count),
      .done              (done),
      .kernel_cycles     (kernel_cycles)
   );

   always #5 clk = ~clk;

   int      checks = 0;
   int      passes = 0;
   int      cyc = 0;
   blk_t    exp_q[$];
   int      exp_total = 0;
   int      issued = 0;
   int      frees = 0;
   int      launch_cyc = -1;
   int      done_cyc = BIG;
   int      stop_cyc = BIG;
   bit      in_reset = 1'b1;
   bit      sync_mode = 1'b0;
   bit      avail[NC];
   bit      busy_resp[NC];
   int      due[NC];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
      else
         passes++;
   endtask

   task automatic model_clear();
      exp_q.delete();
      issued     = 0;
      frees      = 0;
      launch_cyc = -1;
      done_cyc   = BIG;
      stop_cyc   = BIG;
      core_done  = '0;
      for (int i = 0; i < NC; i++) begin
         avail[i]     = 1'b1;
         busy_resp[i] = 1'b0;
         due[i]       = 0;
      end
   endtask

   // Reference: ceil(tc/TPB) blocks, all full except a possibly short last one.
   task automatic model_launch(input int tc);
      model_clear();
      exp_total = (tc + TPB - 1) / TPB;
      for (int b = 0; b < exp_total; b++) begin
         blk_t blk;
         blk.id  = b;
         blk.cnt = (b == exp_total - 1) ? tc - b * TPB : TPB;
         exp_q.push_back(blk);
      end
      launch_cyc = cyc + 1;
      if (exp_total == 0) done_cyc = launch_cyc + 2;
   endtask

   // Monitor plus core responder; samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      logic [NC-1:0] exp_start;
      logic [NC-1:0] exp_rst;
      bit            freed;
      #1;
      cyc++;
      if (!in_reset) begin
         exp_rst = (cyc == launch_cyc) ? '1 : '0;
         chk("core_reset", 32'(core_reset), 32'(exp_rst));

         exp_start = '0;
         if (launch_cyc >= 0 && cyc >= launch_cyc + 2 && issued < exp_total) begin
            for (int i = 0; i < NC; i++)
               if (avail[i] && exp_start == '0) exp_start[i] = 1'b1;
         end
         chk("core_start", 32'(core_start), 32'(exp_start));
         for (int i = 0; i < NC; i++) begin
            if (exp_start[i] && core_start[i]) begin
               blk_t blk;
               if (exp_q.size() == 0) begin
                  chk("scoreboard_empty", 32'(1), 32'(0));
               end else begin
                  blk = exp_q.pop_front();
                  chk("block_id", 32'(core_block_id[i*8 +: 8]), 32'(blk.id));
                  chk("block_threads", 32'(core_thread_count[i*8 +: 8]), 32'(blk.cnt & 8'hFF));
               end
               avail[i]     = 1'b0;
               busy_resp[i] = 1'b1;
               issued++;
               due[i] = sync_mode ? launch_cyc + 5 : cyc + int'($urandom_range(1, 6));
            end
         end

         freed = 1'b0;
         for (int i = 0; i < NC; i++) begin
            if (core_done[i]) begin
               core_done[i] = 1'b0;
               busy_resp[i] = 1'b0;
               avail[i]     = 1'b1;
               frees++;
               freed = 1'b1;
            end
         end
         if (freed && exp_total > 0 && frees == exp_total) done_cyc = cyc + 1;

         chk("done", 32'(done),
             32'(launch_cyc >= 0 && cyc >= done_cyc && cyc < stop_cyc));

         for (int i = 0; i < NC; i++)
            if (busy_resp[i] && !core_done[i] && cyc >= due[i]) core_done[i] = 1'b1;
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_core_reset"}, 32'(core_reset), 32'(0));
      chk({tag, "_core_start"}, 32'(core_start), 32'(0));
      chk({tag, "_block_id"}, 32'(core_block_id), 32'(0));
      chk({tag, "_threads"}, 32'(core_thread_count), 32'(0));
      chk({tag, "_done"}, 32'(done), 32'(0));
      chk({tag, "_kcycles"}, 32'(kernel_cycles), 32'(0));
   endtask

   task automatic run_kernel(input int tc, input bit sync);
      int exp_kc;
      bit seen;
      @(negedge clk);
      sync_mode = sync;
      model_launch(tc);
      thread_count = 8'(tc);
      start = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 2000 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("done_timeout", 32'(seen), 32'(1));
      chk("blocks_issued", 32'(issued), 32'(exp_total));
`ifdef DISPATCH_PERF_EN
      exp_kc = done_cyc - launch_cyc - 1;
`else
      exp_kc = 0;
`endif
      chk("kernel_cycles", 32'(kernel_cycles), 32'(exp_kc));
      repeat (3) @(negedge clk);
      chk("kernel_cycles_hold", 32'(kernel_cycles), 32'(exp_kc));
      start = 1'b0;
      stop_cyc = cyc + 1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      model_clear();
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      reset    = 1'b1;
      in_reset = 1'b0;

      run_kernel(8, 1'b0);
      run_kernel(10, 1'b0);
      run_kernel(0, 1'b0);
      run_kernel(8, 1'b1);
      run_kernel(255, 1'b0);
      for (int r = 0; r < 6; r++) run_kernel(int'($urandom_range(0, 80)), 1'b0);

      // Asynchronous reset landing between edges while blocks are in flight.
      @(negedge clk);
      sync_mode = 1'b0;
      model_launch(40);
      thread_count = 8'd40;
      start = 1'b1;
      repeat (7) @(negedge clk);
      #3;
      in_reset = 1'b1;
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      start = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      reset    = 1'b1;
      in_reset = 1'b0;
      repeat (2) @(negedge clk);
      run_kernel(4, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
